// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, size constants and request-check helpers for
//               the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Legal transfer sizes in bytes
    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    // True when the byte count is one of the supported power-of-two sizes
    function automatic logic size_legal(input logic [3:0] size);
        logic ok;
        ok = (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
        return ok;
    endfunction

    // True when a request must be rejected. The end address is formed one bit
    // wider than the address so a request near 2^64 cannot wrap into range.
    function automatic logic req_error(input logic [63:0] addr,
                                       input logic [3:0]  size,
                                       input logic [64:0] depth);
        logic [64:0] end_addr;
        logic        bad;
        end_addr = {1'b0, addr} + {61'b0, size};
        bad      = 1'b0;
        if (!size_legal(size)) begin
            bad = 1'b1;
        end else if ((addr & {60'b0, size - 4'd1}) != 64'd0) begin
            bad = 1'b1;
        end else if (end_addr > depth) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_array
// Description : Byte-addressed storage with eight byte-lane write enables and
//               a combinational eight-byte read window at a base address.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024
) (
    input  logic                           clk,
    input  logic [7:0]                     we_i,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr_i,
    input  logic [63:0]                    wdata_i,
    output logic [63:0]                    rdata_o
);

    localparam int AW = $clog2(DEPTH_BYTES);

    // Storage is deliberately not reset; contents are undefined until written
    logic [7:0] mem_q [DEPTH_BYTES];

    // Lane i writes byte i of the data word to base+i
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i + AW'(i)] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read window: byte i of the output is the byte at base+i
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rd_lane
            logic [AW-1:0] w_idx;
            assign w_idx                 = addr_i + AW'(gi);
            assign rdata_o[8*gi +: 8]    = mem_q[w_idx];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder. Accepts one load/store at a time,
//               commits it after a fixed latency and returns data or an
//               acknowledgement with an error flag for illegal requests.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [3:0]    size_q, size_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          w_err;
    logic          w_commit;
    logic [7:0]    w_be;
    logic [7:0]    w_size_mask;
    logic [63:0]   w_win;
    logic [63:0]   w_load_data;

    assign w_err = req_error(addr_q, size_q, 65'(DEPTH_BYTES));

    // Byte-lane mask covering the low size bytes, and the zero-extended load
    always_comb begin
        w_size_mask = 8'h00;
        w_load_data = 64'd0;
        case (size_q)
            SZ_B: begin
                w_size_mask = 8'h01;
                w_load_data = {56'd0, w_win[7:0]};
            end
            SZ_H: begin
                w_size_mask = 8'h03;
                w_load_data = {48'd0, w_win[15:0]};
            end
            SZ_W: begin
                w_size_mask = 8'h0F;
                w_load_data = {32'd0, w_win[31:0]};
            end
            SZ_D: begin
                w_size_mask = 8'hFF;
                w_load_data = w_win;
            end
            default: begin
                w_size_mask = 8'h00;
                w_load_data = 64'd0;
            end
        endcase
    end

    assign w_be = w_commit ? w_size_mask : 8'h00;

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_array (
        .clk     (clk),
        .we_i    (w_be),
        .addr_i  (addr_q[AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (w_win)
    );

    // Next-state, capture and response logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        w_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Stores write the array on this edge; loads sample it now,
                    // so they see every store committed on an earlier edge.
                    w_commit = wr_q && !w_err;
                    err_d    = w_err;
                    rdata_d  = (wr_q || w_err) ? 64'd0 : w_load_data;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rdata_d = 64'd0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            size_q  <= 4'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_checks;
    int n_fail;
    logic tied;

    dmem_responder #(
        .DEPTH_BYTES (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready),  64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_rdata"},      resp_rdata,      64'd0);
        chk({tag, "_err"},        64'(resp_err),   64'd0);
    endtask

    // One complete transaction; hold = cycles to keep resp_ready low in RESP,
    // junk = keep a bogus store request asserted while the responder is busy
    task automatic do_op(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                         input logic [3:0] sz, input int hold, input logic junk,
                         output logic [63:0] rd, output logic er);
        int n;
        @(negedge clk);
        chk("req_ready_before", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_size  = sz;
        @(posedge clk);
        #1;
        if (junk) begin
            req_write = 1'b1;
            req_addr  = 64'h40;
            req_wdata = 64'hBADBADBADBADBAD0;
            req_size  = 4'd8;
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (resp_valid) break;
            chk("req_ready_busy", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        chk("resp_latency", 64'(n), 64'(LAT));
        rd = resp_rdata;
        er = resp_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_rdata", resp_rdata, rd);
            chk("hold_err",   64'(resp_err), 64'(er));
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        if (!tied) resp_ready = 1'b1;
        @(posedge clk);
        #1;
        if (!tied) resp_ready = 1'b0;
        chk("post_hs_req_ready",  64'(req_ready),  64'd1);
        chk("post_hs_resp_valid", 64'(resp_valid), 64'd0);
    endtask

    // Safety net against a hung DUT
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    logic [63:0] rd;
    logic        er;
    logic [63:0] pat [4];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        tied       = 1'b0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        req_size   = 4'd0;
        resp_ready = 1'b0;
        pat[0] = 64'h1122334455667788;
        pat[1] = 64'h8877665544332211;
        pat[2] = 64'hA5A5A5A55A5A5A5A;
        pat[3] = 64'h0F0E0D0C0B0A0908;

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b0;

        // Full doubleword store and readback
        do_op(1'b1, 64'h10, 64'h0123456789ABCDEF, 4'd8, 0, 1'b0, rd, er);
        chk("st10_err", 64'(er), 64'd0);
        chk("st10_rdata", rd, 64'd0);
        do_op(1'b0, 64'h10, 64'd0, 4'd8, 0, 1'b0, rd, er);
        chk("ld10_rdata", rd, 64'h0123456789ABCDEF);
        chk("ld10_err", 64'(er), 64'd0);

        // Byte overwrite and sub-word loads
        do_op(1'b1, 64'h12, 64'hFF, 4'd1, 0, 1'b0, rd, er);
        chk("st12_err", 64'(er), 64'd0);
        do_op(1'b0, 64'h10, 64'd0, 4'd8, 0, 1'b0, rd, er);
        chk("ld10b_rdata", rd, 64'h0123456789FFCDEF);
        do_op(1'b0, 64'h14, 64'd0, 4'd4, 0, 1'b0, rd, er);
        chk("ld14_rdata", rd, 64'h0000000001234567);

        // Errors: misaligned, out of range, wrap-around, bad size
        do_op(1'b0, 64'h13, 64'd0, 4'd4, 0, 1'b0, rd, er);
        chk("ld13_err", 64'(er), 64'd1);
        chk("ld13_rdata", rd, 64'd0);
        do_op(1'b1, 64'h3F8, 64'hCAFEBABEDEADBEEF, 4'd8, 0, 1'b0, rd, er);
        chk("st3f8_err", 64'(er), 64'd0);
        do_op(1'b1, 64'h3FC, 64'h1111111111111111, 4'd8, 0, 1'b0, rd, er);
        chk("st3fc_err", 64'(er), 64'd1);
        do_op(1'b0, 64'h3F8, 64'd0, 4'd8, 0, 1'b0, rd, er);
        chk("ld3f8_rdata", rd, 64'hCAFEBABEDEADBEEF);
        chk("ld3f8_err", 64'(er), 64'd0);
        do_op(1'b0, 64'h400, 64'd0, 4'd8, 0, 1'b0, rd, er);
        chk("ld400_err", 64'(er), 64'd1);
        do_op(1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h2222222222222222, 4'd8, 0, 1'b0, rd, er);
        chk("wrap_err", 64'(er), 64'd1);
        do_op(1'b0, 64'h10, 64'd0, 4'd3, 0, 1'b0, rd, er);
        chk("size3_err", 64'(er), 64'd1);
        chk("size3_rdata", rd, 64'd0);
        do_op(1'b0, 64'h3FE, 64'd0, 4'd2, 0, 1'b0, rd, er);
        chk("ld3fe_err", 64'(er), 64'd0);
        chk("ld3fe_rdata", rd, 64'h000000000000CAFE);

        // Back-pressure in RESP
        do_op(1'b0, 64'h10, 64'd0, 4'd2, 5, 1'b0, rd, er);
        chk("hold_ld_rdata", rd, 64'h000000000000CDEF);

        // Reset during ACCESS drops the pending store
        do_op(1'b1, 64'h20, 64'h55, 4'd1, 0, 1'b0, rd, er);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'hAA;
        req_size  = 4'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check_idle("rst_access");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("after_rst");
        do_op(1'b0, 64'h20, 64'd0, 4'd1, 0, 1'b0, rd, er);
        chk("ld20_rdata", rd, 64'h55);

        // Streaming with resp_ready tied high and bogus requests while busy
        do_op(1'b1, 64'h40, 64'h0000000000C0FFEE, 4'd8, 0, 1'b0, rd, er);
        tied       = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, 64'h80 + 64'(8*i), pat[i], 4'd8, 0, 1'b1, rd, er);
            chk("stream_st_err", 64'(er), 64'd0);
            do_op(1'b0, 64'h80 + 64'(8*i), 64'd0, 4'd8, 0, 1'b1, rd, er);
            chk("stream_ld_rdata", rd, pat[i]);
        end
        tied       = 1'b0;
        resp_ready = 1'b0;
        do_op(1'b0, 64'h40, 64'd0, 4'd8, 0, 1'b0, rd, er);
        chk("ld40_untouched", rd, 64'h0000000000C0FFEE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
